// File: rtl/ddr_axi_guard_pkg.sv
// State encoding and AXI response codes for the DDR calibration guard.
package ddr_axi_guard_pkg;

  typedef enum logic [2:0] {
    IDLE, ERR_WDATA, ERR_BRESP, ERR_RDATA, PASS, DRAIN
  } guard_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [15:0] ERR_CNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/types_amba_pkg.sv
// Shared AXI4 bus types for the system interconnect.
// Field layout is common to every AXI slave in the SoC.
package types_amba_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS  = 48;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic                            lock;
    logic [3:0]                      cache;
    logic [2:0]                      prot;
    logic [3:0]                      qos;
    logic [3:0]                      region;
  } axi4_metadata_type;

  typedef struct packed {
    logic                             aw_valid;
    axi4_metadata_type                aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic                             w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
    logic                             b_ready;
    logic                             ar_valid;
    axi4_metadata_type                ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_slave_in_type;

  typedef struct packed {
    logic                             aw_ready;
    logic                             w_ready;
    logic                             b_valid;
    logic [1:0]                       b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
    logic                             ar_ready;
    logic                             r_valid;
    logic [1:0]                       r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
    logic                             r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
  } axi4_slave_out_type;

endpackage

// File: rtl/axi_err_responder.sv
// Terminates one AXI transaction at a time with SLVERR while DDR is uncalibrated.
// Writes win over reads when both address channels are valid in the same cycle.
module axi_err_responder
  import types_amba_pkg::*;
  import ddr_axi_guard_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          aw_valid,
  input  logic [CFG_SYSBUS_ID_BITS-1:0] aw_id,
  input  logic                          ar_valid,
  input  logic [CFG_SYSBUS_ID_BITS-1:0] ar_id,
  input  logic [7:0]                    ar_len,
  input  logic                          w_valid,
  input  logic                          w_last,
  input  logic                          b_ready,
  input  logic                          r_ready,
  output axi4_slave_out_type            xslvo,
  output logic                          idle,
  output logic [15:0]                   err_cnt
);

  guard_state_e                  state, state_n;
  logic [CFG_SYSBUS_ID_BITS-1:0] id_q;
  logic [7:0]                    beat_cnt;
  logic                          aw_hs, ar_hs, r_hs, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    xslvo   = '0;
    aw_hs   = 1'b0;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          xslvo.aw_ready = 1'b1;
          xslvo.ar_ready = !aw_valid;
          if (aw_valid) begin
            aw_hs   = 1'b1;
            state_n = ERR_WDATA;
          end else if (ar_valid) begin
            ar_hs   = 1'b1;
            state_n = ERR_RDATA;
          end
        end
      end
      ERR_WDATA: begin
        xslvo.w_ready = 1'b1;
        if (w_valid && w_last) state_n = ERR_BRESP;
      end
      ERR_BRESP: begin
        xslvo.b_valid = 1'b1;
        xslvo.b_resp  = AXI_RESP_SLVERR;
        xslvo.b_id    = id_q;
        if (b_ready) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      ERR_RDATA: begin
        xslvo.r_valid = 1'b1;
        xslvo.r_resp  = AXI_RESP_SLVERR;
        xslvo.r_id    = id_q;
        xslvo.r_last  = (beat_cnt == 8'd0);
        if (r_ready) begin
          r_hs = 1'b1;
          if (beat_cnt == 8'd0) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat counter holds remaining beats after the current one; err_cnt saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (aw_hs) begin
        id_q <= aw_id;
      end else if (ar_hs) begin
        id_q     <= ar_id;
        beat_cnt <= ar_len;
      end else if (r_hs && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
      if (done && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: rtl/ddr_axi_guard.sv
// AXI4 front-end for the DDR controller: SLVERR until calibration, then masked pass-through.
// Outstanding counters let a calibration drop drain in-flight DDR traffic before erroring.
module ddr_axi_guard
  import types_amba_pkg::*;
  import ddr_axi_guard_pkg::*;
#(
  parameter int CFG_ADDR_BITS        = 30,
  parameter int CFG_OUTSTANDING_BITS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_calib_done,
  input  axi4_slave_in_type  i_xslvi,
  output axi4_slave_out_type o_xslvo,
  output axi4_slave_in_type  o_ddr_xslvi,
  input  axi4_slave_out_type i_ddr_xslvo,
  output logic               o_pass,
  output logic [15:0]        o_err_cnt
);

  localparam logic [CFG_OUTSTANDING_BITS-1:0] CNT_ONE = 1;

  guard_state_e                    mode, mode_n;
  logic [CFG_OUTSTANDING_BITS-1:0] wr_cnt, rd_cnt;
  logic                            wr_full, rd_full, addr_open, data_open;
  logic                            wr_inc, wr_dec, rd_inc, rd_dec;
  logic                            err_enable, err_idle;
  axi4_slave_out_type              err_xslvo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mode <= IDLE;
    else       mode <= mode_n;
  end

  always_comb begin
    mode_n = mode;
    case (mode)
      IDLE:    if (i_calib_done && err_idle) mode_n = PASS;
      PASS:    if (!i_calib_done) mode_n = DRAIN;
      DRAIN: begin
        if (i_calib_done)                          mode_n = PASS;
        else if (wr_cnt == '0 && rd_cnt == '0)     mode_n = IDLE;
      end
      default: mode_n = IDLE;
    endcase
  end

  assign addr_open  = (mode == PASS);
  assign data_open  = (mode == PASS) || (mode == DRAIN);
  assign wr_full    = &wr_cnt;
  assign rd_full    = &rd_cnt;
  assign err_enable = (mode == IDLE) && !i_calib_done;
  assign o_pass     = (mode == PASS);

  axi_err_responder u_err (
    .clk      (i_clk),
    .rst      (i_rst),
    .enable   (err_enable),
    .aw_valid (i_xslvi.aw_valid),
    .aw_id    (i_xslvi.aw_id),
    .ar_valid (i_xslvi.ar_valid),
    .ar_id    (i_xslvi.ar_id),
    .ar_len   (i_xslvi.ar_bits.len),
    .w_valid  (i_xslvi.w_valid),
    .w_last   (i_xslvi.w_last),
    .b_ready  (i_xslvi.b_ready),
    .r_ready  (i_xslvi.r_ready),
    .xslvo    (err_xslvo),
    .idle     (err_idle),
    .err_cnt  (o_err_cnt)
  );

  // DDR side sees the bus verbatim except for the masked address and gated handshakes.
  always_comb begin
    o_ddr_xslvi                = i_xslvi;
    o_ddr_xslvi.aw_bits.addr   = '0;
    o_ddr_xslvi.ar_bits.addr   = '0;
    o_ddr_xslvi.aw_bits.addr[CFG_ADDR_BITS-1:0] = i_xslvi.aw_bits.addr[CFG_ADDR_BITS-1:0];
    o_ddr_xslvi.ar_bits.addr[CFG_ADDR_BITS-1:0] = i_xslvi.ar_bits.addr[CFG_ADDR_BITS-1:0];
    o_ddr_xslvi.aw_valid = addr_open && !wr_full && i_xslvi.aw_valid;
    o_ddr_xslvi.ar_valid = addr_open && !rd_full && i_xslvi.ar_valid;
    o_ddr_xslvi.w_valid  = data_open && i_xslvi.w_valid;
    o_ddr_xslvi.b_ready  = data_open && i_xslvi.b_ready;
    o_ddr_xslvi.r_ready  = data_open && i_xslvi.r_ready;
  end

  always_comb begin
    if (data_open) begin
      o_xslvo          = i_ddr_xslvo;
      o_xslvo.b_user   = '0;
      o_xslvo.r_user   = '0;
      o_xslvo.aw_ready = addr_open && !wr_full && i_ddr_xslvo.aw_ready;
      o_xslvo.ar_ready = addr_open && !rd_full && i_ddr_xslvo.ar_ready;
    end else begin
      o_xslvo = err_xslvo;
    end
  end

  assign wr_inc = o_ddr_xslvi.aw_valid && i_ddr_xslvo.aw_ready;
  assign wr_dec = data_open && i_ddr_xslvo.b_valid && i_xslvi.b_ready && (wr_cnt != '0);
  assign rd_inc = o_ddr_xslvi.ar_valid && i_ddr_xslvo.ar_ready;
  assign rd_dec = data_open && i_ddr_xslvo.r_valid && i_xslvi.r_ready && i_ddr_xslvo.r_last
                  && (rd_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_inc && !wr_dec)      wr_cnt <= wr_cnt + CNT_ONE;
      else if (!wr_inc && wr_dec) wr_cnt <= wr_cnt - CNT_ONE;
      if (rd_inc && !rd_dec)      rd_cnt <= rd_cnt + CNT_ONE;
      else if (!rd_inc && rd_dec) rd_cnt <= rd_cnt - CNT_ONE;
    end
  end

endmodule
